// File: rtl/hue_pkg.sv
// Shared types for the hue sequencer: the six colour-wheel phases and
// the phase-advance helper.
package hue_pkg;

  localparam int NUM_PHASES = 6;

  // Each name lists which channel is held high, ramping up or ramping down.
  typedef enum logic [2:0] {
    PH_R_GUP = 3'd0,
    PH_RDN_G = 3'd1,
    PH_G_BUP = 3'd2,
    PH_GDN_B = 3'd3,
    PH_RUP_B = 3'd4,
    PH_R_BDN = 3'd5
  } phase_t;

  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      PH_R_GUP: n = PH_RDN_G;
      PH_RDN_G: n = PH_G_BUP;
      PH_G_BUP: n = PH_GDN_B;
      PH_GDN_B: n = PH_RUP_B;
      PH_RUP_B: n = PH_R_BDN;
      default:  n = PH_R_GUP;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/hue_sequencer_if.sv
// Control and duty-output bundle of the hue sequencer; the master side
// drives enable/restart and observes the three duty values and phase.
interface hue_sequencer_if #(
  parameter int DW = 11
);
  logic          en;
  logic          restart;
  logic [DW-1:0] r_duty;
  logic [DW-1:0] g_duty;
  logic [DW-1:0] b_duty;
  logic [2:0]    phase;
  logic          wrap;

  modport master (
    output en,
    output restart,
    input  r_duty,
    input  g_duty,
    input  b_duty,
    input  phase,
    input  wrap
  );

  modport slave (
    input  en,
    input  restart,
    output r_duty,
    output g_duty,
    output b_duty,
    output phase,
    output wrap
  );
endinterface

// File: rtl/hue_sequencer_tick_gen.sv
// Free-running step divider: pulses o_tick on every CYCLES-th enabled clock.
// Disabled clocks hold the count so no partial step is lost.
module tick_gen #(
  parameter int CYCLES = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_tick = i_en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_en) begin
      if (o_tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hue_sequencer.sv
// Six-phase colour wheel feeding three PWM generators: one channel ramps
// per phase so the hue moves continuously with no jumps at boundaries.
module hue_sequencer
  import hue_pkg::*;
#(
  parameter int DUTY_MAX    = 2000,
  parameter int STEP_CYCLES = 2000,
  localparam int DW         = $clog2(DUTY_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_restart,
  output logic [DW-1:0] o_r_duty,
  output logic [DW-1:0] o_g_duty,
  output logic [DW-1:0] o_b_duty,
  output logic [2:0]    o_phase,
  output logic          o_wrap
);
  localparam logic [DW-1:0] MAX       = DW'(DUTY_MAX);
  localparam logic [DW-1:0] RAMP_LAST = DW'(DUTY_MAX - 1);

  logic          tick;
  logic [DW-1:0] ramp_q;
  logic [DW-1:0] ramp_d;
  phase_t        phase_q;
  phase_t        phase_d;
  logic          wrap_q;
  logic          wrap_d;
  logic [DW-1:0] ramp_inv;

  tick_gen #(
    .CYCLES (STEP_CYCLES)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (i_restart),
    .i_en   (i_en),
    .o_tick (tick)
  );

  // Phase register is the sequencer state; the ramp is its sub-step.
  always_comb begin
    ramp_d  = ramp_q;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    if (tick) begin
      if (ramp_q < RAMP_LAST) begin
        ramp_d = ramp_q + 1'b1;
      end else begin
        ramp_d  = '0;
        phase_d = next_phase(phase_q);
        wrap_d  = (phase_q == PH_R_BDN);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      ramp_q  <= '0;
      phase_q <= PH_R_GUP;
      wrap_q  <= 1'b0;
    end else begin
      ramp_q  <= ramp_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
    end
  end

  // ramp never exceeds MAX-1, so this DW-bit subtraction cannot wrap.
  assign ramp_inv = MAX - ramp_q;

  always_comb begin
    o_r_duty = MAX;
    o_g_duty = '0;
    o_b_duty = '0;
    case (phase_q)
      PH_R_GUP: begin
        o_r_duty = MAX;
        o_g_duty = ramp_q;
        o_b_duty = '0;
      end
      PH_RDN_G: begin
        o_r_duty = ramp_inv;
        o_g_duty = MAX;
        o_b_duty = '0;
      end
      PH_G_BUP: begin
        o_r_duty = '0;
        o_g_duty = MAX;
        o_b_duty = ramp_q;
      end
      PH_GDN_B: begin
        o_r_duty = '0;
        o_g_duty = ramp_inv;
        o_b_duty = MAX;
      end
      PH_RUP_B: begin
        o_r_duty = ramp_q;
        o_g_duty = '0;
        o_b_duty = MAX;
      end
      PH_R_BDN: begin
        o_r_duty = MAX;
        o_g_duty = '0;
        o_b_duty = ramp_inv;
      end
      default: begin
        o_r_duty = MAX;
        o_g_duty = '0;
        o_b_duty = '0;
      end
    endcase
  end

  assign o_phase = phase_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_hue_sequencer.sv
// Bench for hue_sequencer: unit A (DUTY_MAX=4, STEP_CYCLES=3) and
// unit B (DUTY_MAX=2, STEP_CYCLES=1) against an enabled-clock-count model.
module tb_hue_sequencer;
  localparam int DA  = 4;
  localparam int SA  = 3;
  localparam int DB  = 2;
  localparam int SB  = 1;
  localparam int DWA = 3;
  localparam int DWB = 2;
  localparam int W   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  hue_sequencer_if #(.DW(DWA)) if_a ();
  hue_sequencer_if #(.DW(DWB)) if_b ();

  hue_sequencer #(.DUTY_MAX(DA), .STEP_CYCLES(SA)) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .i_en      (if_a.en),
    .i_restart (if_a.restart),
    .o_r_duty  (if_a.r_duty),
    .o_g_duty  (if_a.g_duty),
    .o_b_duty  (if_a.b_duty),
    .o_phase   (if_a.phase),
    .o_wrap    (if_a.wrap)
  );

  hue_sequencer #(.DUTY_MAX(DB), .STEP_CYCLES(SB)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .i_en      (if_b.en),
    .i_restart (if_b.restart),
    .o_r_duty  (if_b.r_duty),
    .o_g_duty  (if_b.g_duty),
    .o_b_duty  (if_b.b_duty),
    .o_phase   (if_b.phase),
    .o_wrap    (if_b.wrap)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int  n_m[2];   // enabled clocks since the last reset/restart
  bit  w_m[2];   // expected wrap flag

  typedef struct {
    bit rst;
    bit en;
    int r;
    int g;
    int b;
    int ph;
    bit w;
  } vec_t;
  vec_t tbl[17];

  function automatic logic [W-1:0] pk(bit w, int ph, int r, int g, int b);
    logic [W-1:0] v;
    v = {w, ph[2:0], r[3:0], g[3:0], b[3:0]};
    return v;
  endfunction

  // Reference: t ticks so far, hue position decides phase and ramp.
  function automatic logic [W-1:0] model_out(int u);
    int d, s, t, ph, rp, r, g, b;
    d  = (u == 0) ? DA : DB;
    s  = (u == 0) ? SA : SB;
    t  = n_m[u] / s;
    ph = (t / d) % 6;
    rp = t % d;
    case (ph)
      0:       begin r = d;      g = rp;     b = 0;      end
      1:       begin r = d - rp; g = d;      b = 0;      end
      2:       begin r = 0;      g = d;      b = rp;     end
      3:       begin r = 0;      g = d - rp; b = d;      end
      4:       begin r = rp;     g = 0;      b = d;      end
      default: begin r = d;      g = 0;      b = d - rp; end
    endcase
    return pk(w_m[u], ph, r, g, b);
  endfunction

  function automatic logic [W-1:0] act(int u);
    logic [W-1:0] v;
    if (u == 0) begin
      v = {if_a.wrap, if_a.phase, 1'b0, if_a.r_duty, 1'b0, if_a.g_duty, 1'b0, if_a.b_duty};
    end else begin
      v = {if_b.wrap, if_b.phase, 2'b0, if_b.r_duty, 2'b0, if_b.g_duty, 2'b0, if_b.b_duty};
    end
    return v;
  endfunction

  task automatic model_update(int u, bit r, bit rs, bit en);
    int d, s;
    d = (u == 0) ? DA : DB;
    s = (u == 0) ? SA : SB;
    if (r || rs) begin
      n_m[u] = 0;
      w_m[u] = 1'b0;
    end else if (en) begin
      n_m[u] = n_m[u] + 1;
      w_m[u] = (n_m[u] % s == 0) && ((n_m[u] / s) % (6 * d) == 0);
    end else begin
      w_m[u] = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(int u, bit r, bit rs, bit en);
    if (u == 0) begin
      rst_a = r; if_a.restart = rs; if_a.en = en;
    end else begin
      rst_b = r; if_b.restart = rs; if_b.en = en;
    end
  endtask

  task automatic step(int u, bit r, bit rs, bit en);
    drive(u, r, rs, en);
    @(posedge clk);
    model_update(0, rst_a, if_a.restart, if_a.en);
    model_update(1, rst_b, if_b.restart, if_b.en);
    #1;
  endtask

  task automatic check_val(string name, logic [W-1:0] a, logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic check_model(int u, string name);
    exp_q.push_back(model_out(u));
    check_val(name, act(u), exp_q.pop_front());
  endtask

  function automatic int ch_diff(logic [W-1:0] x, logic [W-1:0] y);
    int s;
    s = 0;
    for (int k = 0; k < 3; k++) begin
      int a, b;
      a = int'(x[k*4 +: 4]);
      b = int'(y[k*4 +: 4]);
      s += (a > b) ? (a - b) : (b - a);
    end
    return s;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] prev;
    logic [W-1:0] cur;
    int wraps;
    int cnt;
    int last_wrap;
    bit gap_ok;

    n_m[0] = 0; n_m[1] = 0; w_m[0] = 1'b0; w_m[1] = 1'b0;
    drive(1, 1'b1, 1'b0, 1'b0);

    // Reset held two cycles, then phase 0 ramp into phase 1.
    tbl[0]  = '{1, 1, 4, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 4, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 4, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 4, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 4, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, 4, 1, 0, 0, 0};
    tbl[6]  = '{0, 1, 4, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 4, 2, 0, 0, 0};
    tbl[8]  = '{0, 1, 4, 2, 0, 0, 0};
    tbl[9]  = '{0, 1, 4, 2, 0, 0, 0};
    tbl[10] = '{0, 1, 4, 3, 0, 0, 0};
    tbl[11] = '{0, 1, 4, 3, 0, 0, 0};
    tbl[12] = '{0, 1, 4, 3, 0, 0, 0};
    tbl[13] = '{0, 1, 4, 4, 0, 1, 0};
    tbl[14] = '{0, 1, 4, 4, 0, 1, 0};
    tbl[15] = '{0, 1, 4, 4, 0, 1, 0};
    tbl[16] = '{0, 1, 3, 4, 0, 1, 0};
    for (int i = 0; i < 17; i++) begin
      step(0, tbl[i].rst, 1'b0, tbl[i].en);
      check_val($sformatf("tbl_%0d", i), act(0),
                pk(tbl[i].w, tbl[i].ph, tbl[i].r, tbl[i].g, tbl[i].b));
    end

    // Full wheel: 72 enabled clocks, one wrap pulse, single-step changes.
    step(0, 1'b1, 1'b0, 1'b1);
    prev  = act(0);
    wraps = 0;
    for (int k = 1; k <= 72; k++) begin
      step(0, 1'b0, 1'b0, 1'b1);
      check_model(0, $sformatf("wheel_%0d", k));
      cur = act(0);
      if (cur[15]) wraps++;
      if (ch_diff(cur, prev) > 1) begin
        checks++; errors++;
        $display("FAIL wheel_step_%0d: got %h after %h, more than one unit change", k, cur, prev);
      end
      prev = cur;
      if (k == 42) check_val("phase3_ramp2", cur, pk(0, 3, 0, 2, 4));
      if (k == 72) check_val("wheel_end", cur, pk(1, 0, 4, 0, 0));
    end
    check_val("wheel_wrap_count", W'(wraps), W'(1));
    step(0, 1'b0, 1'b0, 1'b1);
    check_val("wrap_one_cycle", act(0), pk(0, 0, 4, 0, 0));

    // Enable hold mid-step, then resume.
    step(0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(0, 1'b0, 1'b0, 1'b0);
      check_val($sformatf("hold_%0d", k), act(0), pk(0, 0, 4, 1, 0));
    end
    cnt = 0;
    do begin
      step(0, 1'b0, 1'b0, 1'b1);
      cnt++;
      cur = act(0);
    end while (cur[7:4] == 4'd1 && cnt < 10);
    check_val("hold_resume_delay", W'(cnt), W'(2));
    check_model(0, "hold_resume_value");

    // Restart, then reset, at phase 4 with i_en low.
    for (int pass = 0; pass < 2; pass++) begin
      step(0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 53; k++) step(0, 1'b0, 1'b0, 1'b1);
      check_val($sformatf("pre_clear_%0d", pass), act(0), pk(0, 4, 1, 0, 4));
      step(0, pass == 1, pass == 0, 1'b0);
      check_val($sformatf("clear_%0d", pass), act(0), pk(0, 0, 4, 0, 0));
    end

    // Restart coinciding with the 5->0 tick: clear wins, no wrap pulse.
    step(0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 71; k++) step(0, 1'b0, 1'b0, 1'b1);
    check_model(0, "pre_wrap_restart");
    step(0, 1'b0, 1'b1, 1'b1);
    check_val("restart_beats_wrap", act(0), pk(0, 0, 4, 0, 0));

    // Random traffic on unit A.
    for (int k = 0; k < 800; k++) begin
      step(0, $urandom_range(0, 99) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0);
      check_model(0, $sformatf("rand_a_%0d", k));
    end
    drive(0, 1'b0, 1'b0, 1'b0);

    // Unit B: one step per clock, 12-clock wheel.
    step(1, 1'b1, 1'b0, 1'b1);
    check_val("b_reset", act(1), pk(0, 0, 2, 0, 0));
    wraps = 0;
    last_wrap = 0;
    gap_ok = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step(1, 1'b0, 1'b0, 1'b1);
      check_model(1, $sformatf("b_wheel_%0d", k));
      cur = act(1);
      if (k == 1) check_val("b_first_step", cur, pk(0, 0, 2, 1, 0));
      if (k == 2) check_val("b_second_step", cur, pk(0, 1, 2, 2, 0));
      if (cur[15]) begin
        wraps++;
        if (k - last_wrap != 12) gap_ok = 1'b0;
        last_wrap = k;
      end
    end
    check_val("b_wrap_count", W'(wraps), W'(3));
    check_val("b_wrap_period", W'(gap_ok), W'(1));
    for (int k = 0; k < 200; k++) begin
      step(1, $urandom_range(0, 99) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0);
      check_model(1, $sformatf("rand_b_%0d", k));
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
